fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage RISC-V pipeline.
//  - Per-operand forwarding select for NUM_SRC source operands.
//  - Load-use stall/bubble detection.
//  - Variable-latency load wait FSM with pipeline freeze and timeout error.
//  - Saturating stall-cycle performance counter.

---
 rtl/fwd_hazard_unit.sv | 121 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use hazard detection, variable-latency load wait FSM
// with timeout, and a saturating stall-cycle counter for a 5-stage pipeline.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned LOAD_LAT_MAX = 4,
  parameter int unsigned WCNT_W       = 3,
  parameter int unsigned SCNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      mem_memread,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      dmem_ready,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      pipe_freeze,
  output logic                      mem_err,
  output logic [SCNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {StIdle, StMemWait, StError} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                load_use;
  logic                freeze;

  // Register 0 is hardwired zero, so it never forwards and never hazards.
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (mem_regwrite && (mem_rd != '0) && (ex_rs_addr[i*REG_AW +: REG_AW] == mem_rd)) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if (wb_regwrite && (wb_rd != '0) &&
                   (ex_rs_addr[i*REG_AW +: REG_AW] == wb_rd)) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end
      if (ex_memread && (ex_rd != '0) && id_rs_used[i] &&
          (id_rs_addr[i*REG_AW +: REG_AW] == ex_rd)) begin
        load_use = 1'b1;
      end
    end
    if (!rst_n) begin
      fwd_sel  = '0;
      load_use = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_memread && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(LOAD_LAT_MAX)) begin
          freeze    = 1'b1;
          state_d   = StError;
          mem_err_d = 1'b1;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      StError: freeze = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_freeze  = rst_n & freeze;
    stall_if_id  = rst_n & (freeze | load_use);
    // While frozen the ID/EX register holds, so a bubble would be lost anyway.
    bubble_id_ex = rst_n & load_use & ~freeze;
    stall_cnt_d  = stall_cnt_q;
    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vectors plus a per-cycle
// comparison against a behavioural model of the forwarding and freeze rules.
module tb_fwd_hazard_unit;

  localparam int unsigned AW  = 5;
  localparam int unsigned NS  = 2;
  localparam int unsigned LAT = 4;
  localparam int unsigned SW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*AW-1:0] id_rs_addr, ex_rs_addr;
  logic [NS-1:0]   id_rs_used;
  logic [AW-1:0]   ex_rd, mem_rd, wb_rd;
  logic            ex_memread, mem_regwrite, mem_memread, wb_regwrite, dmem_ready;
  logic [2*NS-1:0] fwd_sel;
  logic            stall_if_id, bubble_id_ex, pipe_freeze, mem_err;
  logic [SW-1:0]   stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: freeze cycles spent on the current load, sticky error, stall total.
  int m_pend  = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;

  fwd_hazard_unit #(
    .REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT_MAX(LAT), .WCNT_W(3), .SCNT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .dmem_ready(dmem_ready), .fwd_sel(fwd_sel),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .pipe_freeze(pipe_freeze),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*NS-1:0] exp_fwd();
    logic [2*NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] rs = ex_rs_addr[i*AW +: AW];
      if (mem_regwrite && mem_rd != 0 && rs == mem_rd)      r[2*i +: 2] = 2'b10;
      else if (wb_regwrite && wb_rd != 0 && rs == wb_rd)    r[2*i +: 2] = 2'b01;
    end
    return rst_n ? r : '0;
  endfunction

  function automatic bit exp_load_use();
    bit h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (ex_memread && ex_rd != 0 && id_rs_used[i] && id_rs_addr[i*AW +: AW] == ex_rd) h = 1'b1;
    return rst_n && h;
  endfunction

  function automatic bit exp_freeze();
    if (!rst_n) return 1'b0;
    if (m_err) return 1'b1;
    if (m_pend > 0) return !dmem_ready;
    return mem_memread && !dmem_ready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= 0; m_err <= 1'b0; m_stall <= 0;
    end else begin
      if (!m_err) begin
        if (exp_freeze()) begin
          // The (LAT+1)-th consecutive freeze cycle is the one that times out.
          if (m_pend + 1 > LAT) begin m_err <= 1'b1; m_pend <= 0; end
          else m_pend <= m_pend + 1;
        end else m_pend <= 0;
      end
      if (exp_freeze() || exp_load_use()) m_stall <= (m_stall >= 15) ? 15 : m_stall + 1;
    end
  end

  always @(negedge clk) begin
    check("fwd_sel", 32'(fwd_sel), 32'(exp_fwd()));
    check("pipe_freeze", 32'(pipe_freeze), 32'(exp_freeze()));
    check("stall_if_id", 32'(stall_if_id), 32'(exp_freeze() | exp_load_use()));
    check("bubble_id_ex", 32'(bubble_id_ex), 32'(exp_load_use() & !exp_freeze()));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_addr = '0; id_rs_used = '0; ex_rs_addr = '0; ex_rd = '0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with hazard-looking inputs: combinational outputs must stay low.
    clear_inputs();
    rst_n = 1'b0;
    ex_rs_addr = {5'd9, 5'd3}; mem_rd = 5'd3; mem_regwrite = 1'b1; mem_memread = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs_addr = {5'd0, 5'd3}; id_rs_used = 2'b01;
    tick(); tick();
    #1;
    check("rst_fwd", 32'(fwd_sel), 32'h0);
    check("rst_freeze", 32'(pipe_freeze), 32'h0);
    check("rst_stall", 32'(stall_if_id), 32'h0);
    check("rst_cnt", 32'(stall_cnt), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);

    tick(); rst_n = 1'b1; clear_inputs();
    ex_rs_addr = {5'd9, 5'd3}; mem_rd = 5'd3; wb_rd = 5'd9;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    #1 check("fwd_split", 32'(fwd_sel), 32'b0110);
    tick(); wb_rd = 5'd3;
    #1 check("fwd_prio", 32'(fwd_sel), 32'b0010);
    tick(); ex_rs_addr = {5'd9, 5'd0}; mem_rd = 5'd0; wb_rd = 5'd9;
    #1 check("fwd_r0", 32'(fwd_sel[1:0]), 32'b00);
    // Small sweep of address patterns, checked by the model.
    for (int i = 0; i < 16; i++) begin
      tick();
      ex_rs_addr = {AW'(i % 4), AW'(i % 3)}; mem_rd = AW'(i % 2); wb_rd = AW'(i % 4);
      mem_regwrite = i[2]; wb_regwrite = i[3];
    end

    tick(); clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs_addr = {5'd5, 5'd7}; id_rs_used = 2'b10;
    #1 check("lu_stall", 32'(stall_if_id), 32'h1);
    check("lu_bubble", 32'(bubble_id_ex), 32'h1);
    tick(); ex_memread = 1'b0;
    #1 check("lu_gone", 32'(stall_if_id), 32'h0);
    tick(); ex_memread = 1'b1; id_rs_used = 2'b00;
    #1 check("lu_unused", 32'(stall_if_id), 32'h0);

    // Load waits three cycles; a load-use hazard inside the freeze gets no bubble.
    tick(); clear_inputs(); mem_memread = 1'b1;
    #1 check("fr_1", 32'(pipe_freeze), 32'h1);
    tick(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs_addr = {5'd5, 5'd7}; id_rs_used = 2'b10;
    #1 check("fr_2", 32'(pipe_freeze), 32'h1);
    check("fr_nobubble", 32'(bubble_id_ex), 32'h0);
    check("fr_stall", 32'(stall_if_id), 32'h1);
    tick(); ex_memread = 1'b0;
    #1 check("fr_3", 32'(pipe_freeze), 32'h1);
    tick(); dmem_ready = 1'b1;
    #1 check("fr_done", 32'(pipe_freeze), 32'h0);
    tick(); clear_inputs();
    #1 check("fr_idle", 32'(pipe_freeze), 32'h0);
    check("fr_err", 32'(mem_err), 32'h0);

    // 20 load-use cycles saturate the 4-bit counter.
    tick(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs_addr = {5'd5, 5'd7}; id_rs_used = 2'b10;
    repeat (20) tick();
    clear_inputs();
    #1 check("sat_cnt", 32'(stall_cnt), 32'hF);

    // Timeout: freeze for LAT+1 cycles, then sticky error.
    tick(); mem_memread = 1'b1;
    n = 0;
    while (!mem_err && n < 12) begin tick(); n++; end
    check("to_cycles", 32'(n), 32'd5);
    check("to_err", 32'(mem_err), 32'h1);
    dmem_ready = 1'b1; mem_memread = 1'b0;
    #1 check("to_freeze", 32'(pipe_freeze), 32'h1);
    tick(); tick();
    check("to_sticky", 32'(mem_err), 32'h1);
    rst_n = 1'b0;
    #1 check("to_rst_comb", 32'(pipe_freeze), 32'h0);
    tick(); rst_n = 1'b1; clear_inputs();
    #1 check("rec_err", 32'(mem_err), 32'h0);
    check("rec_freeze", 32'(pipe_freeze), 32'h0);
    check("rec_cnt", 32'(stall_cnt), 32'h0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
